// File: rtl/rs_branch.sv
// Branch reservation station: buffers JALR/BNE uops until operands are ready, issues oldest-ready.
// Latency: dispatch with ready operands issues one edge later; a wakeup broadcast issues two edges later.
// Backpressure: rs_full (registered) drops dispatch; fu_b_ready low holds issue only.
package rs_branch_pkg;
  localparam int RS_PREG_W = 7;
  localparam int RS_ROB_W  = 5;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BNE  = 7'b1100011;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [RS_PREG_W-1:0] pd;
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic [RS_ROB_W-1:0]  rob_index;
  } rs_data_t;
endpackage

module rs_branch
  import rs_branch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PREG_W = RS_PREG_W,
  parameter int NUM_WB = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dispatch_valid,
  input  rs_data_t                      dispatch_data,
  input  logic                          dispatch_ps1_rdy,
  input  logic                          dispatch_ps2_rdy,
  output logic                          rs_full,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0] wb_tag,
  input  logic                          fu_b_ready,
  input  logic [RS_ROB_W-1:0]           curr_rob_tag,
  input  logic                          mispredict,
  input  logic [RS_ROB_W-1:0]           mispredict_tag,
  output rs_data_t                      data_out,
  output logic                          issued
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
  rs_data_t         payload_q [DEPTH];
  logic [AW-1:0]    age_q     [DEPTH];

  logic [DEPTH-1:0] hit1, hit2, squash, eligible, valid_n;
  logic             disp_hit1, disp_hit2;
  logic [AW-1:0]    sel_idx, alloc_idx;
  logic             sel_found, has_free, do_issue, do_disp;

  // Squash window is (lo, hi) exclusive over a 16-entry circular tag space.
  function automatic logic in_squash(input logic [RS_ROB_W-1:0] rob,
                                     input logic [RS_ROB_W-1:0] lo,
                                     input logic [RS_ROB_W-1:0] hi);
    logic [3:0] off, span;
    off  = rob[3:0] - lo[3:0];
    span = hi[3:0] - lo[3:0];
    return (off != 4'd0) && (off < span);
  endfunction

  always_comb begin
    hit1      = '0;
    hit2      = '0;
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && wb_tag[k] != '0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (payload_q[i].ps1 == wb_tag[k]) hit1[i] = 1'b1;
          if (payload_q[i].ps2 == wb_tag[k]) hit2[i] = 1'b1;
        end
        if (dispatch_data.ps1 == wb_tag[k]) disp_hit1 = 1'b1;
        if (dispatch_data.ps2 == wb_tag[k]) disp_hit2 = 1'b1;
      end
    end

    eligible  = valid_q & rdy1_q & rdy2_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    has_free  = 1'b0;
    alloc_idx = '0;
    squash    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!sel_found || age_q[i] > age_q[sel_idx])) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
      end
      if (!valid_q[i] && !has_free) begin
        has_free  = 1'b1;
        alloc_idx = AW'(i);
      end
      squash[i] = mispredict && in_squash(payload_q[i].rob_index, mispredict_tag, curr_rob_tag);
    end

    do_issue = fu_b_ready && !mispredict && sel_found;
    do_disp  = dispatch_valid && !rs_full && has_free &&
               !(mispredict && in_squash(dispatch_data.rob_index, mispredict_tag, curr_rob_tag));

    valid_n = valid_q & ~squash;
    if (do_issue) valid_n[sel_idx] = 1'b0;
    if (do_disp)  valid_n[alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rdy1_q   <= '0;
      rdy2_q   <= '0;
      rs_full  <= 1'b0;
      issued   <= 1'b0;
      data_out <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= '0;
        age_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          rdy1_q[i] <= rdy1_q[i] | hit1[i];
          rdy2_q[i] <= rdy2_q[i] | hit2[i];
          if (do_disp && age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
        end
      end
      if (do_disp) begin
        payload_q[alloc_idx] <= dispatch_data;
        rdy1_q[alloc_idx]    <= dispatch_ps1_rdy | disp_hit1;
        // JALR has no second source operand.
        rdy2_q[alloc_idx]    <= (dispatch_data.opcode == OP_JALR) | dispatch_ps2_rdy | disp_hit2;
        age_q[alloc_idx]     <= '0;
      end
      valid_q <= valid_n;
      rs_full <= &valid_n;
      issued  <= do_issue;
      if (do_issue) data_out <= payload_q[sel_idx];
    end
  end
endmodule

// File: tb/tb_rs_branch.sv
// Bench for rs_branch: directed scenarios plus random traffic against an entry-array reference model.
module tb_rs_branch;
  import rs_branch_pkg::*;
  localparam int DEPTH = 4, PREG_W = 7, NUM_WB = 3;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          dispatch_valid, dispatch_ps1_rdy, dispatch_ps2_rdy;
  rs_data_t                      dispatch_data;
  logic                          rs_full, fu_b_ready, mispredict, issued;
  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0] wb_tag;
  logic [4:0]                    curr_rob_tag, mispredict_tag;
  rs_data_t                      data_out;

  always #5 clk = ~clk;

  rs_branch #(.DEPTH(DEPTH), .PREG_W(PREG_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_data(dispatch_data),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .rs_full(rs_full), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .fu_b_ready(fu_b_ready), .curr_rob_tag(curr_rob_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .data_out(data_out), .issued(issued)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit       v;
    bit       r1;
    bit       r2;
    int       age;
    rs_data_t d;
  } ment_t;

  ment_t    m [DEPTH];
  bit       m_full, m_issued;
  rs_data_t m_out;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m[i].v = 0; m[i].r1 = 0; m[i].r2 = 0; m[i].age = 0; m[i].d = '0;
    end
    m_full = 0; m_issued = 0; m_out = '0;
  endtask

  function automatic bit woke(input logic [PREG_W-1:0] t);
    for (int k = 0; k < NUM_WB; k++)
      if (wb_valid[k] && t != 0 && wb_tag[k] == t) return 1;
    return 0;
  endfunction

  // Walks the circular tag ring from mispredict_tag+1 up to (not including) curr_rob_tag.
  function automatic bit in_sq(input logic [4:0] rob);
    int t;
    t = (int'(mispredict_tag) + 1) % 16;
    for (int n = 0; n < 16 && t != int'(curr_rob_tag) % 16; n++) begin
      if (t == int'(rob) % 16) return 1;
      t = (t + 1) % 16;
    end
    return 0;
  endfunction

  task automatic model_step();
    ment_t nx [DEPTH];
    int sel = -1, slot = -1;
    bit iss, acc;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].r1 && m[i].r2 && (sel < 0 || m[i].age > m[sel].age)) sel = i;
      if (!m[i].v && slot < 0) slot = i;
    end
    iss = fu_b_ready && !mispredict && sel >= 0;
    acc = dispatch_valid && !m_full && slot >= 0 && !(mispredict && in_sq(dispatch_data.rob_index));
    for (int i = 0; i < DEPTH; i++) begin
      nx[i] = m[i];
      if (m[i].v) begin
        nx[i].r1 = m[i].r1 | woke(m[i].d.ps1);
        nx[i].r2 = m[i].r2 | woke(m[i].d.ps2);
        if (acc && m[i].age < DEPTH - 1) nx[i].age = m[i].age + 1;
        if (mispredict && in_sq(m[i].d.rob_index)) nx[i].v = 0;
      end
    end
    if (iss) begin
      nx[sel].v = 0;
      m_out = m[sel].d;
    end
    if (acc) begin
      nx[slot].v   = 1;
      nx[slot].r1  = dispatch_ps1_rdy | woke(dispatch_data.ps1);
      nx[slot].r2  = (dispatch_data.opcode == 7'b1100111) | dispatch_ps2_rdy | woke(dispatch_data.ps2);
      nx[slot].age = 0;
      nx[slot].d   = dispatch_data;
    end
    m_issued = iss;
    m_full = 1;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = nx[i];
      if (!nx[i].v) m_full = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("issued", 128'(issued), 128'(m_issued));
    check("rs_full", 128'(rs_full), 128'(m_full));
    check("data_out", 128'(data_out), 128'(m_out));
    dispatch_valid = 0; dispatch_ps1_rdy = 0; dispatch_ps2_rdy = 0;
    wb_valid = '0; mispredict = 0;
  endtask

  function automatic rs_data_t mk_op(input bit jalr, input int ps1, input int ps2, input int rob);
    rs_data_t d;
    d.opcode    = jalr ? OP_JALR : OP_BNE;
    d.func3     = jalr ? 3'b000 : 3'b001;
    d.pc        = $urandom;
    d.imm       = $urandom;
    d.pd        = 7'($urandom_range(1, 63));
    d.ps1       = 7'(ps1);
    d.ps2       = 7'(ps2);
    d.rob_index = 5'(rob);
    return d;
  endfunction

  task automatic send(input bit jalr, input int ps1, input int ps2, input int rob,
                      input bit r1, input bit r2);
    dispatch_valid = 1; dispatch_data = mk_op(jalr, ps1, ps2, rob);
    dispatch_ps1_rdy = r1; dispatch_ps2_rdy = r2;
  endtask

  int q [$];

  initial begin
    reset = 1; dispatch_valid = 0; dispatch_ps1_rdy = 0; dispatch_ps2_rdy = 0;
    dispatch_data = '0; wb_valid = '0; wb_tag = '0; fu_b_ready = 1;
    curr_rob_tag = 0; mispredict = 0; mispredict_tag = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_issued", 128'(issued), 128'(0));
    check("rst_full", 128'(rs_full), 128'(0));
    check("rst_data", 128'(data_out), 128'(0));

    // BNE with ready operands issues one edge after dispatch.
    send(0, 5, 6, 3, 1, 1); cycle(); cycle();
    check("t1_issued", 128'(issued), 128'(1));
    check("t1_rob", 128'(data_out.rob_index), 128'(3));
    check("t1_full", 128'(rs_full), 128'(0));

    // JALR waits only on ps1; wakeup broadcast issues two edges later.
    send(1, 12, 20, 9, 0, 0); cycle(); cycle();
    wb_valid[1] = 1; wb_tag[1] = 7'd12; cycle();
    check("t2_not_yet", 128'(issued), 128'(0));
    cycle();
    check("t2_issued", 128'(issued), 128'(1));
    check("t2_rob", 128'(data_out.rob_index), 128'(9));

    // Fill, drop a fifth dispatch, then wake all and expect oldest-first.
    for (int i = 0; i < 4; i++) begin send(0, 30 + i, 1, 4 + i, 0, 1); cycle(); end
    check("t3_full", 128'(rs_full), 128'(1));
    send(0, 2, 2, 8, 1, 1); cycle();
    for (int k = 0; k < 3; k++) begin wb_valid[k] = 1; wb_tag[k] = 7'(30 + k); end
    cycle();
    wb_valid[0] = 1; wb_tag[0] = 7'd33;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (issued) q.push_back(int'(data_out.rob_index));
    end
    check("t3_count", 128'(q.size()), 128'(4));
    for (int i = 0; i < q.size(); i++) check("t3_order", 128'(q[i]), 128'(4 + i));

    // Squash window (14, 2) keeps rob 14 only; no issue in the mispredict cycle.
    fu_b_ready = 0;
    send(0, 1, 1, 14, 1, 1); cycle();
    for (int i = 0; i < 3; i++) begin send(0, 41 + i, 1, (15 + i) % 16, 0, 1); cycle(); end
    fu_b_ready = 1; mispredict = 1; mispredict_tag = 14; curr_rob_tag = 2; cycle();
    check("t4_no_issue", 128'(issued), 128'(0));
    check("t4_full", 128'(rs_full), 128'(0));
    for (int k = 0; k < 3; k++) begin wb_valid[k] = 1; wb_tag[k] = 7'(41 + k); end
    cycle();
    check("t4_keep", 128'(data_out.rob_index), 128'(14));
    q.delete();
    for (int c = 0; c < 4; c++) begin cycle(); if (issued) q.push_back(1); end
    check("t4_squashed", 128'(q.size()), 128'(0));

    // fu_b_ready held low stalls issue only.
    fu_b_ready = 0; send(0, 3, 3, 10, 1, 1); cycle();
    for (int c = 0; c < 3; c++) begin cycle(); check("t5_stall", 128'(issued), 128'(0)); end
    fu_b_ready = 1; cycle();
    check("t5_go", 128'(issued), 128'(1));

    // Reset while one issue is in flight and another entry is selected.
    send(0, 3, 3, 11, 1, 1); cycle();
    send(0, 3, 3, 12, 1, 1); cycle();
    reset = 1; #1;
    check("t6_async", 128'(issued), 128'(0));
    @(posedge clk); #1;
    model_reset();
    check("t6_issued", 128'(issued), 128'(0));
    check("t6_full", 128'(rs_full), 128'(0));
    reset = 0;
    for (int c = 0; c < 3; c++) begin wb_valid = '1; wb_tag = '1; cycle(); end

    for (int c = 0; c < 1500; c++) begin
      fu_b_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        send($urandom_range(0, 3) == 0, $urandom_range(0, 20), $urandom_range(0, 20),
             $urandom_range(0, 31), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      for (int k = 0; k < NUM_WB; k++) begin
        wb_valid[k] = 1'($urandom_range(0, 1));
        wb_tag[k]   = 7'($urandom_range(0, 20));
      end
      curr_rob_tag = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 11) == 0) begin
        mispredict     = 1;
        mispredict_tag = 5'($urandom_range(0, 31));
        curr_rob_tag   = mispredict_tag + 5'($urandom_range(1, 15));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_branch.md
# rs_branch

Branch reservation station that feeds the single-cycle branch functional unit. It buffers dispatched JALR/BNE micro-ops until their source physical registers are ready, then issues the oldest ready entry, one per cycle, as a registered `rs_data` plus an `issued` strobe. The unit wakes entries from the result broadcast buses and squashes wrong-path entries on a branch mispredict.

## Interface
- `DEPTH`, 4: number of entries (2..8).
- `PREG_W`, 7: physical register tag width.
- `NUM_WB`, 3: number of wakeup broadcast ports (ALU, LSU, branch).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `dispatch_valid` in 1: dispatch request.
- `dispatch_data` in rs_data: micro-op (Opcode, func3, pc, imm, pd, ps1, ps2, rob_index).
- `dispatch_ps1_rdy` / `dispatch_ps2_rdy` in 1 each: busy-table ready bits at dispatch.
- `rs_full` out 1: no free entry; dispatch is ignored while high.
- `wb_valid` in NUM_WB: broadcast valid per port.
- `wb_tag` in NUM_WB×PREG_W: broadcast physical tags.
- `fu_b_ready` in 1: FU can accept an issue this cycle.
- `curr_rob_tag` in 5: ROB tail (next tag to allocate).
- `mispredict` in 1: mispredict pulse from the branch FU.
- `mispredict_tag` in 5: ROB tag of the mispredicting branch.
- `data_out` out rs_data: issued micro-op, registered.
- `issued` out 1: one-cycle strobe qualifying `data_out`.

## Operation
- Per-entry state: `valid`, rs_data payload, `rdy1`, `rdy2`, and an age counter of width clog2(DEPTH).
- Dispatch: when `dispatch_valid` is high and `rs_full` is low, write into the lowest-index free entry.
  - `rdy1 = dispatch_ps1_rdy | (ps1 matches any valid wb_tag this cycle)`; `rdy2` is computed the same way.
  - JALR (Opcode 1100111) sets `rdy2 = 1` regardless of inputs.
  - The new entry gets age 0. Every other valid entry increments its age, saturating at DEPTH-1.
- Wakeup: each valid entry sets `rdy1`/`rdy2` when its ps1/ps2 equals any `wb_tag[k]` with `wb_valid[k]`. Tag 0 never matches.
- Select: an entry is eligible if `valid & rdy1 & rdy2`. Pick the eligible entry with the largest age; ties go to the lowest index.
- Issue: if `fu_b_ready` is high, `mispredict` is low, and an eligible entry exists:
  - On the edge, register its payload into `data_out`, drive `issued = 1`, and clear the entry's `valid`.
  - Otherwise `issued = 0` and `data_out` holds its last value.
- Squash: when `mispredict` is high, clear every valid entry whose rob_index lies in the circular range (`mispredict_tag`, `curr_rob_tag`) over tags 0..15, exclusive at both ends. Wrap goes 15 → 0.
  - If `mispredict_tag + 1 == curr_rob_tag` (after wrap), nothing is squashed.
- `rs_full` is registered and equals "all entries valid" after the edge's updates.
- Ages of surviving entries are unchanged by issue and squash.

## Timing
- Reset values: all `valid = 0`, all ready bits and ages = 0, `rs_full = 0`, `issued = 0`, `data_out = '0`.
- Reset mid-operation drops every entry immediately, including an in-flight `issued`.
- Latency: dispatch accepted at edge N with both operands ready gives `issued = 1` during cycle N+1, assuming `fu_b_ready` and no contention.
- A wakeup broadcast in cycle N makes the entry eligible in cycle N+1, so `issued` appears in cycle N+2.
- Same-cycle wakeup and dispatch of the matching source is bypassed; there is no lost wakeup.
- Dispatch and issue in the same cycle when full: the dispatch is still rejected, because `rs_full` is registered.
- Mispredict in the same cycle as a dispatch:
  - The dispatched op is written only if its rob_index is outside the squash range.
  - No issue occurs that cycle.
- `issued` is never high for two consecutive cycles from the same entry.
- `fu_b_ready` low has no effect on wakeup, dispatch, or squash.

## Test plan
- Reset, then dispatch BNE rob 3 with ps1/ps2 ready, `fu_b_ready = 1` → `issued = 1` one cycle later, `data_out.rob_index = 3`, `rs_full = 0`.
- Dispatch JALR with ps1 = 12 not ready, then broadcast `wb_tag = 12` two cycles later → `issued` exactly two cycles after the broadcast (N+2), and `rdy2` is ignored.
- Fill 4 entries with unready sources → `rs_full = 1`; a 5th dispatch is dropped. Wake all → issue order is oldest first, one per cycle, 4 `issued` pulses.
- Entries rob 14, 15, 0, 1; `mispredict_tag = 14`, `curr_rob_tag = 2` → rob 15, 0, 1 squashed, rob 14 retained, no issue that cycle.
- Eligible entry with `fu_b_ready = 0` for 3 cycles → no issue; `fu_b_ready` rises → `issued` the next cycle.
- Assert `reset` in the same cycle as a select → next cycle `issued = 0`, `rs_full = 0`, all entries empty.
